// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
//   Shared constants and types for the memory-stage load/store sequencer.
//   Contents:
//     LOAD / STORE          opcode constants
//     F3_B/H/W/BU/HU        Funct3 access size/sign encodings
//     lsu_state_t           sequencer FSM states
//     f3_illegal()          Funct3 legality per access direction
//     misaligned()          natural-alignment check for the access size
// -----------------------------------------------------------------------------
package riscv_pkg;

    localparam logic [6:0] LOAD  = 7'b0000011;
    localparam logic [6:0] STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2,
        DONE   = 2'd3
    } lsu_state_t;

    // Unsigned variants only make sense for loads; 011/110/111 are never legal.
    function automatic logic f3_illegal(input logic is_store, input logic [2:0] f3);
        case (f3)
            F3_B, F3_H, F3_W: f3_illegal = 1'b0;
            F3_BU, F3_HU:     f3_illegal = is_store;
            default:          f3_illegal = 1'b1;
        endcase
    endfunction

    // Size is encoded in f3[1:0]: 00 byte, 01 half, 10 word.
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b10:   misaligned = (off != 2'b00);
            2'b01:   misaligned = off[0];
            default: misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// -----------------------------------------------------------------------------
// load_extend
//   Combinational lane selection and sign/zero extension of a returned
//   data-memory word.
//   Ports:
//     rdata    in   raw read word from memory
//     offset   in   byte offset of the access within the word
//     Funct3   in   access size/sign
//     ext_data out  extended load result (word loads pass through)
// -----------------------------------------------------------------------------
module load_extend
    import riscv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rdata,
    input  logic [1:0]       offset,
    input  logic [2:0]       Funct3,
    output logic [WIDTH-1:0] ext_data
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    assign sel_byte = rdata[{offset, 3'b000} +: 8];
    // Half accesses are aligned, so only offset[1] picks the lane.
    assign sel_half = rdata[{offset[1], 4'b0000} +: 16];

    always_comb begin
        case (Funct3)
            F3_B:    ext_data = {{(WIDTH-8){sel_byte[7]}}, sel_byte};
            F3_H:    ext_data = {{(WIDTH-16){sel_half[15]}}, sel_half};
            F3_BU:   ext_data = {{(WIDTH-8){1'b0}}, sel_byte};
            F3_HU:   ext_data = {{(WIDTH-16){1'b0}}, sel_half};
            default: ext_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//   Memory-stage load/store sequencer. Turns the ALU effective address and
//   rs2 store data into a handshaked data-memory request with byte enables,
//   extends returned load data into data_mem for writeback, and stalls the
//   pipeline until the access completes.
//
//   Optional build macro: LSU_TIMEOUT_EN -- when defined, an access stuck in
//   REQ/WAIT_R for TIMEOUT_CYCLES cycles is aborted with a mem_fault pulse.
//   When undefined the unit waits indefinitely.
//
//   Ports:
//     clk, reset                clock / asynchronous active-high reset
//     issue_valid, Opcode,      instruction in the memory stage
//     Funct3, aluResult, rs2_data
//     mem_req, mem_we, mem_addr,  request to data memory (held until mem_gnt)
//     mem_be, mem_wdata
//     mem_gnt, mem_rvalid,      memory handshake and read data
//     mem_rdata
//     stall                     freeze upstream pipeline (combinational)
//     data_mem, data_valid      extended load result and its update pulse
//     mem_fault                 pulse on misalign / illegal Funct3 / timeout
// -----------------------------------------------------------------------------
module mem_access_unit
    import riscv_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int ADDR_W         = 9,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              issue_valid,
    input  logic [6:0]        Opcode,
    input  logic [2:0]        Funct3,
    input  logic [WIDTH-1:0]  aluResult,
    input  logic [WIDTH-1:0]  rs2_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [WIDTH-1:0]  mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [WIDTH-1:0]  mem_rdata,
    output logic              stall,
    output logic [WIDTH-1:0]  data_mem,
    output logic              data_valid,
    output logic              mem_fault
);

    lsu_state_t       state_reg;
    logic [2:0]       f3_reg;
    logic [1:0]       off_reg;

    logic             is_store;
    logic             memop;
    logic             fault;
    logic             accept;
    logic             timeout_hit;
    logic [3:0]       store_be;
    logic [WIDTH-1:0] store_wdata;
    logic [WIDTH-1:0] byte_rep;
    logic [WIDTH-1:0] half_rep;
    logic [WIDTH-1:0] ext_data;
    logic             unused_addr_bits;

    assign unused_addr_bits = ^aluResult[WIDTH-1:ADDR_W+2];

    assign is_store = (Opcode == STORE);
    assign memop    = issue_valid && ((Opcode == LOAD) || is_store);
    assign fault    = f3_illegal(is_store, Funct3) || misaligned(Funct3, aluResult[1:0]);
    assign accept   = (state_reg == IDLE) && memop && !fault;

    assign stall = (state_reg == REQ) || (state_reg == WAIT_R) || accept;

    // Store lane replication.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH/8; gi++) begin : g_byte_rep
            assign byte_rep[gi*8 +: 8] = rs2_data[7:0];
        end
        for (gi = 0; gi < WIDTH/16; gi++) begin : g_half_rep
            assign half_rep[gi*16 +: 16] = rs2_data[15:0];
        end
    endgenerate

    always_comb begin
        store_be    = 4'b1111;
        store_wdata = rs2_data;
        if (is_store) begin
            case (Funct3)
                F3_B: begin
                    store_be    = 4'b0001 << aluResult[1:0];
                    store_wdata = byte_rep;
                end
                F3_H: begin
                    store_be    = 4'b0011 << aluResult[1:0];
                    store_wdata = half_rep;
                end
                default: ;
            endcase
        end else begin
            store_wdata = '0;
        end
    end

    load_extend #(.WIDTH(WIDTH)) u_load_extend (
        .rdata    (mem_rdata),
        .offset   (off_reg),
        .Funct3   (f3_reg),
        .ext_data (ext_data)
    );

`ifdef LSU_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [TMO_W-1:0] tmo_cnt_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt_reg <= '0;
        end else if (accept) begin
            tmo_cnt_reg <= '0;
        end else if ((state_reg == REQ) || (state_reg == WAIT_R)) begin
            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
        end
    end

    // Last waiting cycle before the abort takes effect at the next edge.
    assign timeout_hit = ((state_reg == REQ) || (state_reg == WAIT_R)) &&
                         (tmo_cnt_reg == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout_hit        = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            f3_reg     <= '0;
            off_reg    <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_be     <= '0;
            mem_wdata  <= '0;
            data_mem   <= '0;
            data_valid <= 1'b0;
            mem_fault  <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            mem_fault  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (memop && fault) begin
                        mem_fault <= 1'b1;
                    end else if (accept) begin
                        mem_req   <= 1'b1;
                        mem_we    <= is_store;
                        mem_addr  <= aluResult[ADDR_W+1:2];
                        mem_be    <= store_be;
                        mem_wdata <= store_wdata;
                        f3_reg    <= Funct3;
                        off_reg   <= aluResult[1:0];
                        state_reg <= REQ;
                    end
                end
                REQ: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        if (mem_we) begin
                            state_reg <= DONE;
                        end else if (mem_rvalid) begin
                            data_mem   <= ext_data;
                            data_valid <= 1'b1;
                            state_reg  <= DONE;
                        end else begin
                            state_reg <= WAIT_R;
                        end
                    end else if (timeout_hit) begin
                        mem_req   <= 1'b0;
                        mem_fault <= 1'b1;
                        state_reg <= DONE;
                    end
                end
                WAIT_R: begin
                    if (mem_rvalid) begin
                        data_mem   <= ext_data;
                        data_valid <= 1'b1;
                        state_reg  <= DONE;
                    end else if (timeout_hit) begin
                        mem_fault <= 1'b1;
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
//   Directed, table-driven bench for mem_access_unit with zero-wait memory,
//   plus hand sequences for delayed grant/read data, stray rvalid, the
//   LSU_TIMEOUT_EN abort (or indefinite wait without it) and async reset.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;
    import riscv_pkg::*;

    logic        clk;
    logic        reset;
    logic        issue_valid;
    logic [6:0]  Opcode;
    logic [2:0]  Funct3;
    logic [31:0] aluResult;
    logic [31:0] rs2_data;
    logic        mem_req;
    logic        mem_we;
    logic [8:0]  mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        stall;
    logic [31:0] data_mem;
    logic        data_valid;
    logic        mem_fault;

    int checks = 0;
    int errors = 0;

    mem_access_unit #(.WIDTH(32), .ADDR_W(9), .TIMEOUT_CYCLES(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .issue_valid (issue_valid),
        .Opcode      (Opcode),
        .Funct3      (Funct3),
        .aluResult   (aluResult),
        .rs2_data    (rs2_data),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_be      (mem_be),
        .mem_wdata   (mem_wdata),
        .mem_gnt     (mem_gnt),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .stall       (stall),
        .data_mem    (data_mem),
        .data_valid  (data_valid),
        .mem_fault   (mem_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] rs2;
        logic [31:0] rdata;
        logic        fault;
        logic [8:0]  e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic [31:0] e_data;   // data_mem after the transaction
    } vec_t;

    localparam int NVEC = 14;
    vec_t vecs [NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        logic st;
        v  = vecs[i];
        st = (v.op == STORE);
        issue_valid = 1'b1;
        Opcode      = v.op;
        Funct3      = v.f3;
        aluResult   = v.addr;
        rs2_data    = v.rs2;
        mem_gnt     = 1'b0;
        mem_rvalid  = 1'b0;
        #1;
        chk("issue_stall", stall, !v.fault);
        step();
        issue_valid = 1'b0;
        Opcode      = 7'b0;
        if (v.fault) begin
            chk("fault_pulse", mem_fault, 1'b1);
            chk("fault_no_req", mem_req, 1'b0);
            chk("fault_stall", stall, 1'b0);
            step();
            chk("fault_end", mem_fault, 1'b0);
            chk("fault_no_req2", mem_req, 1'b0);
            chk("fault_data", data_mem, v.e_data);
        end else begin
            chk("req", mem_req, 1'b1);
            chk("we", mem_we, st);
            chk("addr", mem_addr, v.e_addr);
            chk("be", mem_be, v.e_be);
            if (st) chk("wdata", mem_wdata, v.e_wdata);
            chk("req_stall", stall, 1'b1);
            chk("req_nofault", mem_fault, 1'b0);
            mem_gnt    = 1'b1;
            mem_rvalid = !st;
            mem_rdata  = v.rdata;
            step();
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            chk("done_stall", stall, 1'b0);
            chk("done_req", mem_req, 1'b0);
            chk("done_dv", data_valid, !st);
            chk("done_data", data_mem, v.e_data);
            step();
            chk("idle_dv", data_valid, 1'b0);
        end
        $display("vec %0d op=%b f3=%b addr=0x%08h -> data_mem=0x%08h fault=%0b",
                 i, v.op, v.f3, v.addr, data_mem, v.fault);
    endtask

    task automatic issue_lw(input logic [31:0] addr);
        issue_valid = 1'b1;
        Opcode      = LOAD;
        Funct3      = F3_W;
        aluResult   = addr;
        step();
        issue_valid = 1'b0;
        Opcode      = 7'b0;
    endtask

    initial begin
        //            op     f3     addr          rs2           rdata         flt  e_addr  e_be     e_wdata       e_data
        vecs[0]  = '{LOAD,  F3_B,  32'h103, 32'h0,        32'h80FF1234, 1'b0, 9'h040, 4'b1111, 32'h0,        32'hFFFFFF80};
        vecs[1]  = '{LOAD,  F3_HU, 32'h102, 32'h0,        32'h80FF1234, 1'b0, 9'h040, 4'b1111, 32'h0,        32'h000080FF};
        vecs[2]  = '{STORE, F3_B,  32'h101, 32'h000000AB, 32'h0,        1'b0, 9'h040, 4'b0010, 32'hABABABAB, 32'h000080FF};
        vecs[3]  = '{LOAD,  F3_W,  32'h002, 32'h0,        32'h0,        1'b1, 9'h0,   4'b0,    32'h0,        32'h000080FF};
        vecs[4]  = '{LOAD,  3'b011, 32'h100, 32'h0,       32'h0,        1'b1, 9'h0,   4'b0,    32'h0,        32'h000080FF};
        vecs[5]  = '{LOAD,  F3_W,  32'h1FC, 32'h0,        32'hDEADBEEF, 1'b0, 9'h07F, 4'b1111, 32'h0,        32'hDEADBEEF};
        vecs[6]  = '{LOAD,  F3_H,  32'h004, 32'h0,        32'h00008001, 1'b0, 9'h001, 4'b1111, 32'h0,        32'hFFFF8001};
        vecs[7]  = '{LOAD,  F3_H,  32'h006, 32'h0,        32'h12348001, 1'b0, 9'h001, 4'b1111, 32'h0,        32'h00001234};
        vecs[8]  = '{LOAD,  F3_BU, 32'h001, 32'h0,        32'h0000F000, 1'b0, 9'h000, 4'b1111, 32'h0,        32'h000000F0};
        vecs[9]  = '{STORE, F3_H,  32'h012, 32'h1234CDEF, 32'h0,        1'b0, 9'h004, 4'b1100, 32'hCDEFCDEF, 32'h000000F0};
        vecs[10] = '{STORE, F3_W,  32'h020, 32'h01020304, 32'h0,        1'b0, 9'h008, 4'b1111, 32'h01020304, 32'h000000F0};
        vecs[11] = '{STORE, F3_H,  32'h011, 32'h0,        32'h0,        1'b1, 9'h0,   4'b0,    32'h0,        32'h000000F0};
        vecs[12] = '{STORE, F3_BU, 32'h000, 32'h0,        32'h0,        1'b1, 9'h0,   4'b0,    32'h0,        32'h000000F0};
        vecs[13] = '{LOAD,  F3_B,  32'h002, 32'h0,        32'h007F0000, 1'b0, 9'h000, 4'b1111, 32'h0,        32'h0000007F};

        reset       = 1'b1;
        issue_valid = 1'b0;
        Opcode      = 7'b0;
        Funct3      = 3'b0;
        aluResult   = 32'h0;
        rs2_data    = 32'h0;
        mem_gnt     = 1'b0;
        mem_rvalid  = 1'b0;
        mem_rdata   = 32'h0;
        step();
        step();
        chk("rst_req", mem_req, 1'b0);
        chk("rst_we", mem_we, 1'b0);
        chk("rst_be", mem_be, 4'b0);
        chk("rst_addr", mem_addr, 9'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        chk("rst_data", data_mem, 32'h0);
        chk("rst_dv", data_valid, 1'b0);
        chk("rst_fault", mem_fault, 1'b0);
        chk("rst_stall", stall, 1'b0);
        reset = 1'b0;
        step();

        for (int i = 0; i < NVEC; i++) run_vec(i);

        // Non-memory opcode is ignored.
        issue_valid = 1'b1;
        Opcode      = 7'b0110011;
        Funct3      = F3_W;
        aluResult   = 32'h003;
        #1;
        chk("alu_stall", stall, 1'b0);
        step();
        issue_valid = 1'b0;
        chk("alu_req", mem_req, 1'b0);
        chk("alu_fault", mem_fault, 1'b0);
        $display("seq non-memop: req=%0b fault=%0b", mem_req, mem_fault);

        // LW with grant delayed 3 cycles and read data 2 cycles after grant.
        issue_lw(32'h040);
        for (int k = 0; k < 3; k++) begin
            chk("dly_req", mem_req, 1'b1);
            chk("dly_addr", mem_addr, 9'h010);
            chk("dly_be", mem_be, 4'b1111);
            chk("dly_stall", stall, 1'b1);
            chk("dly_dv", data_valid, 1'b0);
            step();
        end
        mem_gnt = 1'b1;
        chk("dly_gnt_req", mem_req, 1'b1);
        chk("dly_gnt_addr", mem_addr, 9'h010);
        step();
        mem_gnt = 1'b0;
        chk("wait_req", mem_req, 1'b0);
        chk("wait_stall", stall, 1'b1);
        chk("wait_dv", data_valid, 1'b0);
        step();
        chk("wait_stall2", stall, 1'b1);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hCAFEF00D;
        step();
        mem_rvalid = 1'b0;
        chk("dly_done_dv", data_valid, 1'b1);
        chk("dly_done_data", data_mem, 32'hCAFEF00D);
        chk("dly_done_stall", stall, 1'b0);
        step();
        chk("dly_dv_once", data_valid, 1'b0);
        $display("seq delayed-gnt LW: data_mem=0x%08h", data_mem);

        // Stray rvalid while idle is ignored.
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h11111111;
        step();
        mem_rvalid = 1'b0;
        chk("stray_dv", data_valid, 1'b0);
        chk("stray_data", data_mem, 32'hCAFEF00D);
        $display("seq stray rvalid: data_mem=0x%08h", data_mem);

`ifdef LSU_TIMEOUT_EN
        // Grant withheld: abort after 4 cycles in REQ.
        issue_lw(32'h080);
        for (int k = 0; k < 4; k++) begin
            chk("tmo_req", mem_req, 1'b1);
            chk("tmo_nofault", mem_fault, 1'b0);
            step();
        end
        chk("tmo_fault", mem_fault, 1'b1);
        chk("tmo_req_drop", mem_req, 1'b0);
        chk("tmo_stall", stall, 1'b0);
        chk("tmo_dv", data_valid, 1'b0);
        chk("tmo_data", data_mem, 32'hCAFEF00D);
        step();
        chk("tmo_fault_end", mem_fault, 1'b0);
        chk("tmo_idle_stall", stall, 1'b0);
        $display("seq timeout: fault pulsed, data_mem=0x%08h", data_mem);
`else
        // Grant withheld for a long time: the unit keeps waiting.
        issue_lw(32'h080);
        for (int k = 0; k < 8; k++) begin
            chk("hold_req", mem_req, 1'b1);
            chk("hold_stall", stall, 1'b1);
            chk("hold_nofault", mem_fault, 1'b0);
            step();
        end
        mem_gnt    = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0BADF00D;
        step();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        chk("hold_dv", data_valid, 1'b1);
        chk("hold_data", data_mem, 32'h0BADF00D);
        step();
        $display("seq long wait: data_mem=0x%08h", data_mem);
`endif

        // Reset asserted in REQ drops mem_req without a clock edge.
        issue_lw(32'h000);
        chk("rreq_req", mem_req, 1'b1);
        reset = 1'b1;
        #1;
        chk("rreq_req_drop", mem_req, 1'b0);
        chk("rreq_stall", stall, 1'b0);
        step();
        reset = 1'b0;
        step();
        $display("seq reset in REQ: req=%0b", mem_req);

        // Reset asserted in WAIT_R; later rvalid is ignored.
        issue_lw(32'h000);
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        chk("rwait_stall_pre", stall, 1'b1);
        reset = 1'b1;
        #1;
        chk("rwait_stall", stall, 1'b0);
        chk("rwait_req", mem_req, 1'b0);
        step();
        reset = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h55AA55AA;
        step();
        mem_rvalid = 1'b0;
        chk("rwait_dv", data_valid, 1'b0);
        chk("rwait_data", data_mem, 32'h0);
        chk("rwait_stall_post", stall, 1'b0);
        step();
        chk("rwait_data2", data_mem, 32'h0);
        $display("seq reset in WAIT_R: data_mem=0x%08h", data_mem);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
